// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 transmitter. Sends one command byte to the
// keyboard by inhibiting the bus, issuing a request-to-send start bit, then
// shifting data, parity and stop on device clock falling edges and sampling
// the device ACK. The pins are only ever pulled low (open-drain enables).
module ps2_tx #(
    parameter int counterBits = 16,
    parameter int inhibitClk  = 2500,
    parameter int timeoutClk  = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    input  logic       start,
    input  logic [7:0] txData,
    output logic       ps2ClkLow,
    output logic       ps2DataLow,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [counterBits-1:0] INHIBIT_LAST = counterBits'(inhibitClk - 1);
    localparam logic [counterBits-1:0] TIMEOUT_LAST = counterBits'(timeoutClk - 1);
    localparam logic [counterBits-1:0] COUNT_ONE    = counterBits'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_ACK,
        S_WAITIDLE
    } state_t;

    // Synchronizer and edge-detect history for the shared pins.
    logic r_clk_meta, r_clk_sync, r_clk_prev;
    logic r_dat_meta, r_dat_sync;

    // Frame state.
    state_t                 r_state,     w_state_nxt;
    logic [7:0]             r_shift,     w_shift_nxt;
    logic                   r_parity,    w_parity_nxt;
    logic [counterBits-1:0] r_count,     w_count_nxt;
    logic [2:0]             r_idx,       w_idx_nxt;
    logic                   r_clk_low,   w_clk_low_nxt;
    logic                   r_data_low,  w_data_low_nxt;
    logic                   r_busy,      w_busy_nxt;
    logic                   r_done,      w_done_nxt;
    logic                   r_error,     w_error_nxt;

    logic w_fall;
    logic w_timeout;

    assign w_fall    = r_clk_prev & ~r_clk_sync;
    assign w_timeout = (r_count == TIMEOUT_LAST);

    assign ps2ClkLow  = r_clk_low;
    assign ps2DataLow = r_data_low;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

    // Two-flop synchronizers; idle-high reset avoids a phantom falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2Clk;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= ps2Data;
            r_dat_sync <= r_dat_meta;
        end
    end

    // State register: all frame state and the registered pin enables.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_count    <= '0;
            r_idx      <= '0;
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_count    <= w_count_nxt;
            r_idx      <= w_idx_nxt;
            r_clk_low  <= w_clk_low_nxt;
            r_data_low <= w_data_low_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
        end
    end

    // Next-state logic: request sequence, bit shifting, ACK sampling and timeout.
    always_comb begin
        // NOTE: every target gets a default first so no latch is inferred.
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_parity_nxt   = r_parity;
        w_count_nxt    = r_count;
        w_idx_nxt      = r_idx;
        w_clk_low_nxt  = r_clk_low;
        w_data_low_nxt = r_data_low;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_error_nxt    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_shift_nxt   = txData;
                    w_parity_nxt  = ~^txData;
                    w_busy_nxt    = 1'b1;
                    w_clk_low_nxt = 1'b1;
                    w_count_nxt   = '0;
                    w_idx_nxt     = '0;
                    w_state_nxt   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (r_count == INHIBIT_LAST) begin
                    // Clock release and start bit happen on the same edge.
                    w_data_low_nxt = 1'b1;
                    w_clk_low_nxt  = 1'b0;
                    w_count_nxt    = '0;
                    w_state_nxt    = S_DATA;
                end else begin
                    w_count_nxt = r_count + COUNT_ONE;
                end
            end

            S_DATA, S_PARITY, S_STOP, S_ACK: begin
                if (w_fall) begin
                    w_count_nxt = '0;
                    unique case (r_state)
                        S_DATA: begin
                            w_data_low_nxt = ~r_shift[r_idx];
                            if (r_idx == 3'd7) begin
                                w_idx_nxt   = '0;
                                w_state_nxt = S_PARITY;
                            end else begin
                                w_idx_nxt = r_idx + 3'd1;
                            end
                        end
                        S_PARITY: begin
                            w_data_low_nxt = ~r_parity;
                            w_state_nxt    = S_STOP;
                        end
                        S_STOP: begin
                            w_data_low_nxt = 1'b0;
                            w_state_nxt    = S_ACK;
                        end
                        default: begin
                            // ACK: device holds data low to acknowledge.
                            w_done_nxt  = ~r_dat_sync;
                            w_error_nxt = r_dat_sync;
                            w_state_nxt = S_WAITIDLE;
                        end
                    endcase
                end else if (w_timeout) begin
                    w_error_nxt    = 1'b1;
                    w_clk_low_nxt  = 1'b0;
                    w_data_low_nxt = 1'b0;
                    w_busy_nxt     = 1'b0;
                    w_count_nxt    = '0;
                    w_idx_nxt      = '0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_count_nxt = r_count + COUNT_ONE;
                end
            end

            S_WAITIDLE: begin
                if (r_clk_sync && r_dat_sync) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
